// File: rtl/cdc_pkg.sv
// Shared types and default constants for the cross-domain transfer controller.
// Imported by the ack synchronizer and the transfer FSM.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        DRAIN  = 2'd3
    } xfer_state_t;

    localparam int unsigned DEF_WIDTH       = 9;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_TIMEOUT     = 255;

endpackage

// File: rtl/cdc_xfer_ctrl_sync.sv
// Multi-flop synchronizer for a single asynchronous level (the far-side ack).
// All stages clear asynchronously so a stale ack cannot survive reset.
module sync_bit
    import cdc_pkg::*;
#(
    parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
    input  logic clk_ab,
    input  logic rst_ab,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_ab or negedge rst_ab) begin
        if (!rst_ab) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_xfer_ctrl.sv
// Source side of a 4-phase req/ack transfer into an asynchronous domain,
// with a bounded wait for ack and a sticky timeout flag.
module cdc_xfer_ctrl
    import cdc_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk_ab,
    input  logic             rst_ab,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int unsigned   TW   = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TIMEOUT[TW-1:0];

    xfer_state_t   state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          ack_s;
    logic          accept;
    logic          err_set;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_ab (clk_ab),
        .rst_ab (rst_ab),
        .d      (xfer_ack),
        .q      (ack_s)
    );

    assign src_ready = (state == IDLE) && !ack_s;
    assign busy      = (state != IDLE);
    assign accept    = src_valid && src_ready;

    // Ack is tested before the timer limit so a late ack never raises an error.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = REQ_HI;
                    timer_nx = '0;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_nx = REQ_LO;
                end else if (timer == TMAX) begin
                    err_set  = 1'b1;
                    state_nx = DRAIN;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            REQ_LO, DRAIN: begin
                if (!ack_s) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_ab or negedge rst_ab) begin
        if (!rst_ab) begin
            state       <= IDLE;
            timer       <= '0;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nx;
            timer    <= timer_nx;
            xfer_req <= (state_nx == REQ_HI);
            if (accept) begin
                xfer_data <= src_data;
            end
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cdc_xfer_ctrl.md
CDC_XFER_CTRL -- requirements
Module: cdc_xfer_ctrl

Interface
REQ-001 Parameter WIDTH, default 9, sets the payload width in bits.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of flops on the ack synchronizer; legal values are 2 to 4.
REQ-003 Parameter TIMEOUT, default 255, sets the maximum cycles to wait for ack high; legal values are 1 to 65535.
REQ-004 The clk_ab port SHALL be an input, 1 bit wide: the single clock; all state updates on posedge.
REQ-005 The rst_ab port SHALL be an input, 1 bit wide: reset, asynchronous assert, active-low.
REQ-006 The src_valid port SHALL be an input, 1 bit wide: the source offers a word.
REQ-007 The src_data port SHALL be an input, WIDTH bits wide: the offered word.
REQ-008 The src_ready port SHALL be an output, 1 bit wide: the block accepts a word this cycle.
REQ-009 The xfer_req port SHALL be an output, 1 bit wide: the 4-phase request to the far domain.
REQ-010 The xfer_data port SHALL be an output, WIDTH bits wide: held payload, stable while xfer_req=1 and until ack falls.
REQ-011 The xfer_ack port SHALL be an input, 1 bit wide: ack from the far domain, asynchronous to clk_ab.
REQ-012 The busy port SHALL be an output, 1 bit wide: high in any state other than IDLE.
REQ-013 The timeout_err port SHALL be an output, 1 bit wide: sticky flag for an ack timeout.
REQ-014 The err_clr port SHALL be an input, 1 bit wide: a synchronous one-cycle clear of timeout_err.

Function
REQ-015 xfer_ack SHALL pass through SYNC_STAGES flops to form ack_s; only ack_s SHALL be used internally.
REQ-016 The FSM SHALL have states IDLE, REQ_HI, REQ_LO and DRAIN.
REQ-017 src_ready SHALL be 1 only when state=IDLE and ack_s=0; it SHALL be combinational from registered state only.
REQ-018 IDLE: when src_valid=1 and src_ready=1, the block SHALL capture src_data into xfer_data, load the timer with 0, and go to REQ_HI.
REQ-019 xfer_req SHALL be registered and SHALL be 1 exactly while state=REQ_HI, rising 1 cycle after the accept edge.
REQ-020 REQ_HI: if ack_s=1, the block SHALL go to REQ_LO; else if timer=TIMEOUT, it SHALL set timeout_err and go to DRAIN; else timer increments.
REQ-021 REQ_LO: xfer_req=0; the block SHALL go to IDLE when ack_s=0.
REQ-022 DRAIN: xfer_req=0; the block SHALL go to IDLE when ack_s=0, with no timer in this state.
REQ-023 xfer_data SHALL change only on an accept edge and SHALL otherwise hold its value.
REQ-024 The timer SHALL be a counter of width $clog2(TIMEOUT+1) and SHALL never wrap; it saturates at TIMEOUT.
REQ-025 ack_s=1 and timer=TIMEOUT in the same cycle: ack SHALL win, the block goes to REQ_LO, and no error is raised.
REQ-026 err_clr=1 in the same cycle as a new timeout: set SHALL win, and timeout_err remains 1.
REQ-027 If ack_s=1 while in IDLE (stale ack), the block SHALL not accept input (src_ready=0) until ack_s=0.
REQ-028 A minimum full transfer SHALL take 2*SYNC_STAGES+2 cycles from accept edge to the next src_ready=1, given immediate far-side ack.

Reset
REQ-029 rst_ab=0 SHALL asynchronously force state=IDLE, xfer_req=0, xfer_data=0, timer=0, timeout_err=0, and all sync flops=0.
REQ-030 On reset release, src_ready SHALL be 1 on the first edge where ack_s=0.
REQ-031 Reset during REQ_HI SHALL drop xfer_req immediately, with no completion of the handshake.

Structure
REQ-032 A shared package cdc_pkg SHALL hold the state enum xfer_state_t (IDLE, REQ_HI, REQ_LO, DRAIN) and the default constants.
REQ-033 The ack synchronizer SHALL be a sub-module, sync_bit, with parameter STAGES and async active-low reset on rst_ab.
REQ-034 The FSM SHALL use one always_ff for state, timer, data and error, plus one always_comb for next-state.

Verification
REQ-035 Basic transfer: reset, src_valid=1 and src_data=9'h1A5 accepted; far side acks 3 cycles after xfer_req -> xfer_data=9'h1A5 throughout, xfer_req=0 after ack_s, src_ready=1 after ack falls plus SYNC_STAGES.
REQ-036 Timeout: TIMEOUT=8, never ack -> xfer_req high for 9 cycles, then timeout_err=1 and state DRAIN, then IDLE with ack low; err_clr pulse -> timeout_err=0.
REQ-037 Back-pressure: src_valid held with 3 words (9'h001, 9'h002, 9'h003) -> each accepted only in IDLE, and order and values preserved on xfer_data.
REQ-038 Race: ack_s rises on the cycle timer=TIMEOUT -> REQ_LO, with timeout_err=0.
REQ-039 Reset mid-transfer: rst_ab low in REQ_HI -> xfer_req=0 and xfer_data=0 asynchronously, without waiting for clk_ab.
REQ-040 Stale ack: xfer_ack=1 at reset release -> src_ready=0 until xfer_ack=0 plus SYNC_STAGES cycles.
